// File: rtl/median_pkg.sv
// Shared definitions for the median filter datapath: pixel width default,
// 3x3 window element count and the (row, col) -> element index mapping.
package median_pkg;

  localparam int MEDIAN_DATA_W = 8;
  localparam int WIN_N         = 9;

  // Element (r,c) of a packed window sits at slot 3*r+c; r=0 is the oldest row, c=0 the oldest column.
  function automatic int win_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row delay line: a DEPTH-deep shift register that advances only when en is high,
// so dout is the sample accepted DEPTH accepts earlier. Contents are not cleared by reset.
module line_buffer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] r_sr [DEPTH];

  // Freeze while in reset so a restart never shifts in a bogus sample.
  always_ff @(posedge clk) begin
    if (en && !rst) begin
      r_sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign dout = r_sr[DEPTH-1];

endmodule

// File: rtl/window_3x3_generator.sv
// Raster-to-3x3-window producer for the median filter; one interior window per accepted pixel.
// Optional WINDOW_COORD_EN adds out_row/out_col carrying the window centre coordinate.
module window_3x3_generator
  import median_pkg::*;
#(
  parameter int DATA_W = MEDIAN_DATA_W,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_pixel,
  output logic                    out_valid,
  output logic [WIN_N*DATA_W-1:0] out_win,
`ifdef WINDOW_COORD_EN
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col,
`endif
  output logic                    frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]           r_col_p0;
  logic [RW-1:0]           r_row_p0;
  logic [DATA_W-1:0]       w_lb0_dout;
  logic [DATA_W-1:0]       w_lb1_dout;
  logic [DATA_W-1:0]       r_win_p0 [WIN_N];
  logic [DATA_W-1:0]       w_win_nxt [WIN_N];
  logic [WIN_N*DATA_W-1:0] w_win_pack;
  logic                    w_complete;
  logic                    w_last;

  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb0 (
    .clk  (clk),
    .rst  (rst),
    .en   (in_valid),
    .din  (in_pixel),
    .dout (w_lb0_dout)
  );

  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .en   (in_valid),
    .din  (w_lb0_dout),
    .dout (w_lb1_dout)
  );

  // Stage p0 -> next window: shift every row left, oldest row fed from the deepest line buffer.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_win_nxt[win_idx(r, 0)] = r_win_p0[win_idx(r, 1)];
      w_win_nxt[win_idx(r, 1)] = r_win_p0[win_idx(r, 2)];
      w_win_nxt[win_idx(r, 2)] = '0;
    end
    w_win_nxt[win_idx(0, 2)] = w_lb1_dout;
    w_win_nxt[win_idx(1, 2)] = w_lb0_dout;
    w_win_nxt[win_idx(2, 2)] = in_pixel;
    w_win_pack = '0;
    for (int i = 0; i < WIN_N; i++) w_win_pack[DATA_W*i +: DATA_W] = w_win_nxt[i];
  end

  // Row/col gating keeps windows from straddling a row wrap or a frame boundary.
  assign w_complete = in_valid && (r_row_p0 >= RW'(2)) && (r_col_p0 >= CW'(2));
  assign w_last     = (r_row_p0 == ROW_LAST) && (r_col_p0 == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_p0   <= '0;
      r_row_p0   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= w_complete;
      frame_done <= w_complete && w_last;
      if (in_valid) begin
        if (r_col_p0 == COL_LAST) begin
          r_col_p0 <= '0;
          r_row_p0 <= (r_row_p0 == ROW_LAST) ? '0 : r_row_p0 + RW'(1);
        end else begin
          r_col_p0 <= r_col_p0 + CW'(1);
        end
      end
    end
  end

  // Stage p0 -> p1: window registers and the held output window.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN_N; i++) r_win_p0[i] <= '0;
      out_win <= '0;
`ifdef WINDOW_COORD_EN
      out_row <= '0;
      out_col <= '0;
`endif
    end else if (in_valid) begin
      for (int i = 0; i < WIN_N; i++) r_win_p0[i] <= w_win_nxt[i];
      if (w_complete) begin
        out_win <= w_win_pack;
`ifdef WINDOW_COORD_EN
        out_row <= r_row_p0 - RW'(1);
        out_col <= r_col_p0 - CW'(1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_window_3x3_generator.sv
// Scoreboard bench for window_3x3_generator: a frame-array reference model predicts each window,
// a monitor pops and compares whenever out_valid is seen. A 3x3 instance covers the minimum frame.
module tb_window_3x3_generator;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef struct {
    logic [9*DW-1:0] win;
    logic            fd;
    int              cyc;
    int              row;
    int              col;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_pixel = '0;
  logic            out_valid;
  logic [9*DW-1:0] out_win;
  logic            frame_done;
  logic [1:0]      out_row, out_col;

  logic            rst3 = 1'b1;
  logic            v3 = 1'b0;
  logic [DW-1:0]   p3 = '0;
  logic            ov3;
  logic [9*DW-1:0] w3;
  logic            fd3;
  logic [1:0]      r3, c3;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mr = 0, mc = 0;
  logic [DW-1:0] img [H][W];
  logic [9*DW-1:0] last_win = '0;
  exp_t q[$];
  bit   main_done = 1'b0;

  always #5 clk = ~clk;

  window_3x3_generator #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_win    (out_win),
`ifdef WINDOW_COORD_EN
    .out_row    (out_row),
    .out_col    (out_col),
`endif
    .frame_done (frame_done)
  );

  window_3x3_generator #(.DATA_W(DW), .IMG_W(3), .IMG_H(3)) dut3 (
    .clk        (clk),
    .rst        (rst3),
    .in_valid   (v3),
    .in_pixel   (p3),
    .out_valid  (ov3),
    .out_win    (w3),
`ifdef WINDOW_COORD_EN
    .out_row    (r3),
    .out_col    (c3),
`endif
    .frame_done (fd3)
  );

`ifndef WINDOW_COORD_EN
  assign out_row = '0;
  assign out_col = '0;
  assign r3 = '0;
  assign c3 = '0;
`endif

  task automatic chk(input string nm, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: remember the frame, emit the 3x3 neighbourhood ending at each accepted pixel.
  task automatic drive(input bit v, input logic [DW-1:0] pix);
    exp_t e;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = v;
    in_pixel = pix;
    if (v) begin
      img[mr][mc] = pix;
      if (mr >= 2 && mc >= 2) begin
        e.win = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e.win[DW*(3*r+c) +: DW] = img[mr-2+r][mc-2+c];
        e.fd  = (mr == H-1) && (mc == W-1);
        e.cyc = cyc + 1;
        e.row = mr - 1;
        e.col = mc - 1;
        q.push_back(e);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    mr = 0;
    mc = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (rst) begin
      chk("reset_out_valid", {71'd0, out_valid}, '0);
      chk("reset_out_win", out_win, '0);
      chk("reset_frame_done", {71'd0, frame_done}, '0);
      last_win = '0;
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("missed_window", 72'(0), 72'(1));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", {71'd0, out_valid}, '0);
        end else begin
          e = q.pop_front();
          chk("window_latency", 72'(cyc), 72'(e.cyc));
          chk("window_data", out_win, e.win);
          chk("frame_done", {71'd0, frame_done}, {71'd0, e.fd});
`ifdef WINDOW_COORD_EN
          chk("out_row", {70'd0, out_row}, 72'(e.row));
          chk("out_col", {70'd0, out_col}, 72'(e.col));
`endif
          last_win = e.win;
        end
      end else begin
        chk("frame_done_idle", {71'd0, frame_done}, '0);
        chk("out_win_hold", out_win, last_win);
      end
    end
  end

  initial begin
    logic [9*DW-1:0] all_ff;
    int wins3;
    do_reset();
    // Frame of 16*row+col, continuous.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) drive(1'b1, DW'(16*r + c));
    // Same frame with validity 1,0,0 gaps.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        drive(1'b1, DW'(16*r + c));
        drive(1'b0, DW'($urandom));
        drive(1'b0, DW'($urandom));
      end
    // Three back-to-back random frames with random gaps.
    for (int i = 0; i < 3*W*H; i++) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, DW'($urandom));
      drive(1'b1, DW'($urandom));
    end
    // Partial frame, reset, then a clean restart.
    for (int i = 0; i < 6; i++) drive(1'b1, DW'($urandom));
    do_reset();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) drive(1'b1, DW'(16*r + c));
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) drive(1'b1, DW'($urandom));
    repeat (5) drive(1'b0, '0);
    chk("scoreboard_drained", 72'(q.size()), 72'(0));

    // Minimum 3x3 frame of all 255: one window, with frame_done.
    all_ff = '1;
    wins3  = 0;
    @(negedge clk); rst3 = 1'b1; v3 = 1'b0;
    @(negedge clk); rst3 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      v3 = (k < 9);
      p3 = 8'hFF;
      @(posedge clk);
      #1;
      chk("min_out_valid", {71'd0, ov3}, {71'd0, (k == 8)});
      chk("min_frame_done", {71'd0, fd3}, {71'd0, (k == 8)});
      if (ov3) begin
        wins3++;
        chk("min_window", w3, all_ff);
`ifdef WINDOW_COORD_EN
        chk("min_row", {70'd0, r3}, 72'(1));
        chk("min_col", {70'd0, c3}, 72'(1));
`endif
      end
    end
    chk("min_window_count", 72'(wins3), 72'(1));
    main_done = 1'b1;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    if (!main_done) begin
      $display("FAIL watchdog: bench did not complete, %0d/%0d checks passed", n_chk - n_fail, n_chk);
      $fatal(1, "watchdog");
    end
  end

endmodule
